simon_encrypt: RTL and testbench
================================

SIMON_ENCRYPT -- requirements
Module: simon_encrypt

Interface
REQ-001 Parameter WORD, default 64, width of one Simon word and one round key.
REQ-002 Parameter ROUNDS, default 72, number of rounds (Simon128/256).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 res_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  begin an encryption; sampled on the rising edge in IDLE or DONE.
REQ-006 plaintext  input  2*WORD  block; x = [127:64], y = [63:0]; captured on an accepted start.
REQ-007 key_sched  input  WORD  current round key from the upstream key-schedule block.
REQ-008 key_valid  input  1  key_sched holds a valid round key.
REQ-009 key_ready  output  1  block will consume key_sched this cycle.
REQ-010 busy  output  1  high while in RUN.
REQ-011 done  output  1  high while in DONE; ciphertext valid.
REQ-012 ciphertext  output  2*WORD  {x,y} after ROUNDS rounds; held stable while done=1.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, and DONE.
REQ-014 IDLE/DONE with start=1: load x,y from plaintext, clear round counter, go to RUN, drop done on the same edge.
REQ-015 In RUN, key_ready SHALL be 1; in IDLE/DONE, key_ready SHALL be 0.
REQ-016 A round SHALL execute only on an edge where key_valid=1 and key_ready=1 (a transfer).
REQ-017 Each transfer: x' = y ^ f(x) ^ key_sched, y' = x, with f(x) = (rotl(x,1) & rotl(x,8)) ^ rotl(x,2).
REQ-018 Each transfer SHALL increment the round counter (width ceil(log2(ROUNDS+1))) by 1.
REQ-019 In RUN with key_valid=0, x, y, and the counter SHALL hold (stall), with no timeout.
REQ-020 The transfer with counter=ROUNDS-1 SHALL perform the round and move to DONE on the same edge.
REQ-021 With key_valid held high, done SHALL rise exactly ROUNDS clock edges after the start edge.
REQ-022 start in RUN SHALL be ignored; plaintext SHALL be sampled only on an accepted start.
REQ-023 In DONE with start=0, state and ciphertext SHALL hold indefinitely.
REQ-024 ciphertext SHALL always equal {x,y}; it is only meaningful when done=1.
REQ-025 All rotations SHALL be modulo WORD; all XOR/AND operations SHALL be WORD bits wide with no carries.

Reset
REQ-026 res_n=0 SHALL immediately force IDLE, counter=0, x=y=0, key_ready=0, busy=0, done=0, ciphertext=0.
REQ-027 Reset in RUN SHALL abort the operation; no partial result is retained, and a new start is required.
REQ-028 The first start after res_n rises SHALL be accepted on the first rising edge that samples it high.

Structure
REQ-029 Package simon_pkg SHALL hold WORD, ROUNDS, the FSM state typedef, and the rotate amounts 1/8/2.
REQ-030 The round function SHALL be the combinational sub-module simon_round (x, y, k in; x', y' out).
REQ-031 No other sub-modules are required.

Verification
REQ-032 Test vector: plaintext 74206e69206d6f6f6d69732061207369 with key 1f1e...0100 via the keys block -> done=1, ciphertext 8d2b5579afc8a3a03bf72a87efe7b868.
REQ-033 Same vector with key_valid held high, driven by the bench -> done rises exactly 72 edges after the start edge.
REQ-034 key_valid toggled 1-0-0-1 pseudo-randomly -> same ciphertext; x, y, and counter unchanged on every key_valid=0 edge.
REQ-035 res_n pulsed low after 30 transfers -> all outputs 0 immediately; a subsequent full run gives the vector ciphertext.
REQ-036 start=1 pulsed at transfer 10 with a different plaintext -> ignored, vector ciphertext produced.
REQ-037 start in DONE with a new plaintext -> done falls on the next edge, and a second run completes with the correct result.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared constants and FSM state type for the Simon block-cipher encryption core.
package simon_pkg;

  localparam int WORD   = 64;
  localparam int ROUNDS = 72;

  // Rotate-left amounts used by the Simon round function f(x).
  localparam int ROT_A = 1;
  localparam int ROT_B = 8;
  localparam int ROT_C = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/simon_round.sv
// One combinational Simon round: x' = y ^ f(x) ^ k, y' = x.
module simon_round #(
  parameter int WORD = 64
) (
  input  logic [WORD-1:0] x,
  input  logic [WORD-1:0] y,
  input  logic [WORD-1:0] k,
  output logic [WORD-1:0] x_next,
  output logic [WORD-1:0] y_next
);
  import simon_pkg::*;

  logic [WORD-1:0] rot_a;
  logic [WORD-1:0] rot_b;
  logic [WORD-1:0] rot_c;

  assign rot_a = {x[WORD-1-ROT_A:0], x[WORD-1:WORD-ROT_A]};
  assign rot_b = {x[WORD-1-ROT_B:0], x[WORD-1:WORD-ROT_B]};
  assign rot_c = {x[WORD-1-ROT_C:0], x[WORD-1:WORD-ROT_C]};

  assign x_next = y ^ ((rot_a & rot_b) ^ rot_c) ^ k;
  assign y_next = x;

endmodule

// File: rtl/simon_encrypt.sv
// Iterative Simon encryption core: one round per accepted round key from an upstream key schedule.
// Handshake: a round key transfers on a rising edge where key_valid && key_ready; key_ready is high only in RUN.
module simon_encrypt #(
  parameter int WORD   = simon_pkg::WORD,
  parameter int ROUNDS = simon_pkg::ROUNDS
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              start,
  input  logic [2*WORD-1:0] plaintext,
  input  logic [WORD-1:0]   key_sched,
  input  logic              key_valid,
  output logic              key_ready,
  output logic              busy,
  output logic              done,
  output logic [2*WORD-1:0] ciphertext,
  output logic [1:0]        state_dbg
);
  import simon_pkg::*;

  localparam int CW = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0] LAST_ROUND = CW'(ROUNDS - 1);

  state_t          state_q;
  state_t          state_d;
  logic [WORD-1:0] x_q;
  logic [WORD-1:0] y_q;
  logic [CW-1:0]   cnt_q;
  logic [WORD-1:0] x_n;
  logic [WORD-1:0] y_n;
  logic            transfer;
  logic            accept;

  simon_round #(.WORD(WORD)) u_round (
    .x      (x_q),
    .y      (y_q),
    .k      (key_sched),
    .x_next (x_n),
    .y_next (y_n)
  );

  always_comb begin
    state_d   = state_q;
    key_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        key_ready = 1'b1;
        busy      = 1'b1;
        if (key_valid && cnt_q == LAST_ROUND) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign transfer = key_ready && key_valid;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        x_q   <= plaintext[2*WORD-1:WORD];
        y_q   <= plaintext[WORD-1:0];
        cnt_q <= '0;
      end else if (transfer) begin
        x_q   <= x_n;
        y_q   <= y_n;
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign ciphertext = {x_q, y_q};
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_simon_encrypt.sv
// Bench for simon_encrypt: randomized runs scored against a plain-arithmetic Simon128/256 model.
module tb_simon_encrypt;
  localparam int W = 64;
  localparam int R = 72;
  localparam logic [127:0] VEC_PT = 128'h74206e69206d6f6f_6d69732061207369;
  localparam logic [127:0] VEC_CT = 128'h8d2b5579afc8a3a0_3bf72a87efe7b868;

  logic         clk = 1'b0;
  logic         res_n = 1'b1;
  logic         start = 1'b0;
  logic [127:0] plaintext = '0;
  logic [63:0]  key_sched = '0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic         busy;
  logic         done;
  logic [127:0] ciphertext;
  logic [1:0]   state_dbg;

  simon_encrypt #(.WORD(W), .ROUNDS(R)) dut (
    .clk        (clk),
    .res_n      (res_n),
    .start      (start),
    .plaintext  (plaintext),
    .key_sched  (key_sched),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .done       (done),
    .ciphertext (ciphertext),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [127:0] exp_q[$];
  logic [63:0]  rk[R];
  int           checks = 0;
  int           failures = 0;
  int           start_cyc = 0;
  bit           lat_armed = 1'b0;
  logic         done_q = 1'b0;
  logic [127:0] last_exp = '0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] rotl64(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] pt);
    logic [63:0] x, y, t;
    x = pt[127:64];
    y = pt[63:0];
    for (int i = 0; i < R; i++) begin
      t = x;
      x = y ^ ((rotl64(x, 1) & rotl64(x, 8)) ^ rotl64(x, 2)) ^ rk[i];
      y = t;
    end
    return {x, y};
  endfunction

  // Simon128/256 key expansion of key 1f1e...0100.
  task automatic load_vector_keys();
    logic [61:0] z4;
    logic [63:0] tmp;
    z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;
    rk[0] = 64'h0706050403020100;
    rk[1] = 64'h0f0e0d0c0b0a0908;
    rk[2] = 64'h1716151413121110;
    rk[3] = 64'h1f1e1d1c1b1a1918;
    for (int i = 4; i < R; i++) begin
      tmp = rotr64(rk[i-1], 3) ^ rk[i-3];
      tmp = tmp ^ rotr64(tmp, 1);
      rk[i] = 64'hffff_ffff_ffff_fffc ^ rk[i-4] ^ tmp ^ {63'd0, z4[61 - ((i - 4) % 62)]};
    end
  endtask

  task automatic load_random_keys();
    for (int i = 0; i < R; i++) rk[i] = {$urandom(), $urandom()};
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (res_n && done && !done_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done got=%h exp=<none>", ciphertext);
      end else begin
        check("ciphertext", ciphertext, exp_q.pop_front());
      end
      if (lat_armed) check("done_latency", 128'(cyc - start_cyc), 128'(R));
    end
    done_q = done;
  end

  // ---------------- driver ----------------
  task automatic do_run(input logic [127:0] pt, input int valid_pct,
                        input int abort_at, input int poke_at);
    int           idx;
    int           guard;
    bit           pending;
    bit           stall_chk;
    logic [127:0] prev_ct;
    idx = 0; guard = 0; pending = 0; stall_chk = 0; prev_ct = '0;
    @(negedge clk);
    start     = 1'b1;
    plaintext = pt;
    key_valid = 1'b0;
    last_exp  = model_enc(pt);
    exp_q.push_back(last_exp);
    start_cyc = cyc + 1;
    lat_armed = (valid_pct >= 100);
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
    check("busy_after_start", {127'd0, busy}, 128'd1);
    check("done_after_start", {127'd0, done}, 128'd0);
    forever begin
      if (stall_chk) check("stall_hold", ciphertext, prev_ct);
      stall_chk = 0;
      if (done || !busy) break;
      if (guard++ > 2000) begin
        checks++;
        failures++;
        $display("FAIL run_timeout got=%0d transfers exp=%0d", idx, R);
        break;
      end
      if (idx == abort_at) begin
        key_valid = 1'b0;
        #2 res_n = 1'b0;
        #1;
        check("abort_ct", ciphertext, 128'd0);
        check("abort_flags", {125'd0, busy, done, key_ready}, 128'd0);
        void'(exp_q.pop_back());
        @(negedge clk);
        res_n = 1'b1;
        return;
      end
      start = (idx == poke_at);
      if (start) plaintext = ~pt;
      key_valid = ($urandom_range(99) < valid_pct);
      key_sched = (key_valid && idx < R) ? rk[idx] : {$urandom(), $urandom()};
      pending   = key_valid && key_ready;
      if (!key_valid) begin
        prev_ct   = ciphertext;
        stall_chk = 1;
      end
      @(posedge clk);
      if (pending) idx++;
      @(negedge clk);
      start = 1'b0;
    end
    key_valid = 1'b0;
  endtask

  task automatic hold_done_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("done_hold_ct", ciphertext, last_exp);
      check("done_hold_flag", {127'd0, done}, 128'd1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1 res_n = 1'b0;
    #2;
    check("reset_ct", ciphertext, 128'd0);
    check("reset_flags", {125'd0, busy, done, key_ready}, 128'd0);
    check("reset_state", {126'd0, state_dbg}, 128'd0);
    repeat (2) @(negedge clk);
    res_n = 1'b1;

    load_vector_keys();
    check("model_vector", model_enc(VEC_PT), VEC_CT);
    do_run(VEC_PT, 100, -1, -1);
    hold_done_check(4);

    // start while DONE with fresh plaintext and keys
    load_random_keys();
    do_run({$urandom(), $urandom(), $urandom(), $urandom()}, 70, -1, -1);

    load_vector_keys();
    do_run(VEC_PT, 55, -1, -1);
    do_run(VEC_PT, 80, 30, -1);
    do_run(VEC_PT, 100, -1, -1);
    do_run(VEC_PT, 75, -1, 10);

    for (int n = 0; n < 4; n++) begin
      load_random_keys();
      do_run({$urandom(), $urandom(), $urandom(), $urandom()},
             $urandom_range(100, 30), -1, $urandom_range(60, 1));
      hold_done_check(2);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
